// File: rtl/raster_block_pkg.sv
// Shared helpers for the raster-to-block front end: window packing index
// and counter-width derivation.
package raster_block_pkg;

  localparam int DEF_N     = 10;
  localparam int DEF_BLK   = 8;
  localparam int DEF_IMG_W = 128;
  localparam int DEF_IMG_H = 128;

  // Width of a counter covering 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit offset of tile element (r,c) inside a flattened window word.
  function automatic int win_idx(input int r, input int c, input int blk, input int n);
    return (r * blk + c) * n;
  endfunction

  localparam int DEF_ROW_W   = cnt_w(DEF_BLK);
  localparam int DEF_COL_W   = cnt_w(DEF_IMG_W);
  localparam int DEF_TILE_W  = cnt_w(DEF_IMG_W / DEF_BLK);
  localparam int DEF_STRIP_W = cnt_w(DEF_IMG_H / DEF_BLK);

endpackage

// File: rtl/strip_buffer.sv
// One strip bank: BLK rows x IMG_W pixels, single write port and a
// combinational BLKxBLK tile read selected by tile column.
module strip_buffer
  import raster_block_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int BLK   = DEF_BLK,
  parameter int IMG_W = DEF_IMG_W
) (
  input  logic                            clk,
  input  logic                            we,
  input  logic [cnt_w(BLK)-1:0]           wr_row,
  input  logic [cnt_w(IMG_W)-1:0]         wr_col,
  input  logic [N-1:0]                    wr_data,
  input  logic [cnt_w(IMG_W/BLK)-1:0]     rd_tile,
  output logic [N*BLK*BLK-1:0]            tile
);

  localparam int CW = cnt_w(IMG_W);

  logic [N-1:0]    mem [BLK][IMG_W];
  logic [CW-1:0]   col_base;

  // Storage needs no reset: the owning full flag decides whether it is read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_row][wr_col] <= wr_data;
    end
  end

  assign col_base = CW'(rd_tile) * CW'(BLK);

  for (genvar r = 0; r < BLK; r++) begin : g_row
    for (genvar c = 0; c < BLK; c++) begin : g_col
      assign tile[win_idx(r, c, BLK, N) +: N] = mem[r][col_base + CW'(c)];
    end
  end

endmodule

// File: rtl/raster_to_block.sv
// Raster pixel stream in, BLKxBLK tile windows out, through two ping-pong
// strip banks. Pixels are forwarded bit-exact.
module raster_to_block
  import raster_block_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int BLK   = DEF_BLK,
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N-1:0]                     in_pixel,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [N*BLK*BLK-1:0]             out_window,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [cnt_w(IMG_H/BLK)-1:0]      out_blk_row,
  output logic [cnt_w(IMG_W/BLK)-1:0]      out_blk_col,
  output logic                             out_last
);

  localparam int TILES_W = IMG_W / BLK;
  localparam int STRIPS  = IMG_H / BLK;
  localparam int RW      = cnt_w(BLK);
  localparam int CW      = cnt_w(IMG_W);
  localparam int TW      = cnt_w(TILES_W);
  localparam int SW      = cnt_w(STRIPS);
  localparam int WIN_W   = N * BLK * BLK;

  // Handshakes: a transfer happens on the rising edge where valid && ready;
  // valid never waits on ready, and out_* hold while out_valid && !out_ready.
  logic            wr_bank, rd_bank;
  logic [RW-1:0]   wr_row;
  logic [CW-1:0]   wr_col;
  logic [SW-1:0]   wr_strip, rd_strip;
  logic [TW-1:0]   rd_col;
  logic [1:0]      full, full_set, full_clr;
  logic            accept, wr_last_px, load, rd_last_col;
  logic [WIN_W-1:0] tile0, tile1;

  assign in_ready    = !full[wr_bank];
  assign accept      = in_valid && in_ready;
  assign wr_last_px  = (wr_col == CW'(IMG_W - 1)) && (wr_row == RW'(BLK - 1));
  assign load        = full[rd_bank] && (!out_valid || out_ready);
  assign rd_last_col = (rd_col == TW'(TILES_W - 1));

  always_comb begin
    full_set = 2'b00;
    full_clr = 2'b00;
    if (accept && wr_last_px) full_set[wr_bank] = 1'b1;
    if (load && rd_last_col)  full_clr[rd_bank] = 1'b1;
  end

  strip_buffer #(.N(N), .BLK(BLK), .IMG_W(IMG_W)) u_bank0 (
    .clk     (clk),
    .we      (accept && !wr_bank),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (in_pixel),
    .rd_tile (rd_col),
    .tile    (tile0)
  );

  strip_buffer #(.N(N), .BLK(BLK), .IMG_W(IMG_W)) u_bank1 (
    .clk     (clk),
    .we      (accept && wr_bank),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (in_pixel),
    .rd_tile (rd_col),
    .tile    (tile1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank  <= 1'b0;
      wr_row   <= '0;
      wr_col   <= '0;
      wr_strip <= '0;
    end else if (accept) begin
      if (wr_col == CW'(IMG_W - 1)) begin
        wr_col <= '0;
        if (wr_row == RW'(BLK - 1)) begin
          wr_row   <= '0;
          wr_bank  <= ~wr_bank;
          wr_strip <= (wr_strip == SW'(STRIPS - 1)) ? '0 : wr_strip + SW'(1);
        end else begin
          wr_row <= wr_row + RW'(1);
        end
      end else begin
        wr_col <= wr_col + CW'(1);
      end
    end
  end

  // Writer and reader never touch the same bank's flag on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) full <= 2'b00;
    else        full <= (full | full_set) & ~full_clr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank     <= 1'b0;
      rd_col      <= '0;
      rd_strip    <= '0;
      out_valid   <= 1'b0;
      out_window  <= '0;
      out_blk_row <= '0;
      out_blk_col <= '0;
      out_last    <= 1'b0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_window  <= rd_bank ? tile1 : tile0;
      out_blk_row <= rd_strip;
      out_blk_col <= rd_col;
      out_last    <= rd_last_col && (rd_strip == SW'(STRIPS - 1));
      if (rd_last_col) begin
        rd_col   <= '0;
        rd_bank  <= ~rd_bank;
        rd_strip <= (rd_strip == SW'(STRIPS - 1)) ? '0 : rd_strip + SW'(1);
      end else begin
        rd_col <= rd_col + TW'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_raster_to_block.sv
// Directed bench for raster_to_block on a 16x16 image with 8x8 tiles,
// pixel(r,c) = r*16 + c.
module tb_raster_to_block;

  localparam int N     = 10;
  localparam int BLK   = 8;
  localparam int IMG_W = 16;
  localparam int IMG_H = 16;
  localparam int WW    = N * BLK * BLK;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  in_pixel;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] out_window;
  logic          out_valid;
  logic          out_ready;
  logic          out_blk_row;
  logic          out_blk_col;
  logic          out_last;

  int vectors     = 0;
  int miscompares = 0;

  logic [WW-1:0] cap_win[$];
  logic [2:0]    cap_tag[$];
  logic [2:0]    exp_q[$];
  int            accepted, acc_cyc_last, first_vld_cyc, hold_viol;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  raster_to_block #(.N(N), .BLK(BLK), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_pixel    (in_pixel),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_window  (out_window),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_blk_row (out_blk_row),
    .out_blk_col (out_blk_col),
    .out_last    (out_last)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] model_win(input int tr, input int tc, input bit neg);
    logic [WW-1:0] w;
    logic [N-1:0]  v;
    w = '0;
    for (int r = 0; r < BLK; r++) begin
      for (int c = 0; c < BLK; c++) begin
        v = N'((tr * BLK + r) * IMG_W + tc * BLK + c);
        if (neg && tr == 0 && tc == 0 && r == 0 && c == 0) v = '1;
        w[(r * BLK + c) * N +: N] = v;
      end
    end
    return w;
  endfunction

  function automatic logic [WW-1:0] get_win(input int i);
    return (i < cap_win.size()) ? cap_win[i] : '0;
  endfunction

  function automatic logic [N-1:0] elem(input logic [WW-1:0] w, input int i);
    return w[i * N +: N];
  endfunction

  task automatic push_frame_tags();
    exp_q.push_back(3'b000);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b111);
  endtask

  task automatic check_frame(input int base, input bit neg);
    for (int w = 0; w < 4; w++)
      check($sformatf("win%0d", base + w), get_win(base + w), model_win(w / 2, w % 2, neg));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input bit chk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    if (chk) begin
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_window", out_window, 0);
      check("rst_tags", {out_blk_row, out_blk_col, out_last}, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // rdy_mode: 0 = hold low, 1 = always high, 2 = random
  task automatic run_stream(input int npix, input int nwin, input int rdy_mode,
                            input bit vld_rand, input int budget, input bit neg_first);
    bit            prev_stall;
    logic [WW-1:0] prev_win;
    logic [2:0]    prev_tag, tag;
    prev_stall = 1'b0;
    prev_win   = '0;
    prev_tag   = '0;
    cap_win.delete();
    cap_tag.delete();
    accepted = 0; acc_cyc_last = -1; first_vld_cyc = -1; hold_viol = 0;
    for (int k = 0; k < budget; k++) begin
      if (accepted >= npix && cap_win.size() >= nwin) break;
      @(posedge clk);
      #1;
      in_valid  = (accepted < npix) && (vld_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
      in_pixel  = (neg_first && accepted == 0) ? '1 : N'(accepted % 256);
      out_ready = (rdy_mode == 1) ? 1'b1 :
                  (rdy_mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b0;
      @(negedge clk);
      tag = {out_blk_row, out_blk_col, out_last};
      if (prev_stall && (out_window !== prev_win || tag !== prev_tag)) hold_viol++;
      prev_stall = out_valid && !out_ready;
      prev_win   = out_window;
      prev_tag   = tag;
      if (out_valid && first_vld_cyc < 0) first_vld_cyc = k;
      if (in_valid && in_ready) begin
        if (accepted == 127) acc_cyc_last = k;
        accepted++;
      end
      if (out_valid && out_ready) begin
        cap_win.push_back(out_window);
        cap_tag.push_back(tag);
        if (exp_q.size() > 0) check("tag", tag, exp_q.pop_front());
        else                  check("extra_window", 1, 0);
      end
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    // One frame, sink always ready
    do_reset(1);
    push_frame_tags();
    run_stream(256, 4, 1, 1'b0, 600, 1'b0);
    check("f1_win_count", cap_win.size(), 4);
    check("f1_latency", first_vld_cyc - acc_cyc_last, 2);
    check_frame(0, 1'b0);
    check("w0_elem0", elem(get_win(0), 0), 0);
    check("w0_elem9", elem(get_win(0), 9), 17);
    check("w1_elem0", elem(get_win(1), 0), 8);
    check("w3_elem63", elem(get_win(3), 63), 255);
    check("f1_idle_valid", out_valid, 0);

    // Sink stalled: input backs up after two strips
    do_reset(0);
    run_stream(300, 0, 0, 1'b0, 400, 1'b0);
    check("stall_accepted", accepted, 256);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    check("stall_window", out_window, model_win(0, 0, 1'b0));
    check("stall_tags", {out_blk_row, out_blk_col, out_last}, 3'b000);
    check("stall_hold", hold_viol, 0);

    // Reset mid-frame, then a clean frame
    do_reset(0);
    run_stream(70, 0, 1, 1'b0, 100, 1'b0);
    check("mid_accepted", accepted, 70);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_frame_tags();
    run_stream(256, 4, 1, 1'b0, 600, 1'b0);
    check("mid_win_count", cap_win.size(), 4);
    check_frame(0, 1'b0);

    // Negative pixel at (0,0)
    do_reset(0);
    push_frame_tags();
    run_stream(256, 4, 1, 1'b0, 600, 1'b1);
    check("neg_elem0", elem(get_win(0), 0), 10'h3FF);
    check_frame(0, 1'b1);

    // Two frames, random valid/ready
    do_reset(0);
    push_frame_tags();
    push_frame_tags();
    run_stream(512, 8, 2, 1'b1, 6000, 1'b0);
    check("rnd_win_count", cap_win.size(), 8);
    check_frame(0, 1'b0);
    check_frame(4, 1'b0);
    check("rnd_hold", hold_viol, 0);
    check("rnd_exp_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
